// File: rtl/vec_chunk_fifo.sv
// vec_chunk_fifo
// Chunk-granular FIFO that sits between a vector producer and a vector
// consumer. Vectors of InVecLength signed 8-bit elements travel as
// Cpv = InVecLength/WorkingRegs chunks of WorkingRegs elements each. The
// buffer holds VecDepth whole vectors (Cap = VecDepth*Cpv chunks). The read
// side is first-word-fall-through. vec_ready tells the consumer that at least
// one complete vector is stored.
//
// Chunk packing: element i of a chunk occupies bits [8*i+7 : 8*i].
//
// Ports
//   clk_in      : clock, all logic on rising edge
//   rst_in      : synchronous active-high reset
//   wr_chunk    : push wr_data this cycle (ignored while full)
//   wr_data     : chunk to store (WorkingRegs x 8-bit signed)
//   rd_chunk    : pop head chunk this cycle (ignored while empty)
//   rd_data     : head chunk, zero while empty
//   vec_ready   : at least one complete vector is stored
//   rd_vec_last : head chunk is the last chunk of its vector
//   full        : occupancy == Cap
//   empty       : occupancy == 0
//   overflow    : (VEC_CHUNK_FIFO_ERR_EN only) sticky, a write was rejected
//   underflow   : (VEC_CHUNK_FIFO_ERR_EN only) sticky, a read was ignored
//
// Optional feature macro: VEC_CHUNK_FIFO_ERR_EN
module vec_chunk_fifo #(
   parameter int InVecLength = 16,
   parameter int WorkingRegs = 4,
   parameter int VecDepth    = 2
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     wr_chunk,
   input  logic [WorkingRegs*8-1:0] wr_data,
   input  logic                     rd_chunk,
   output logic [WorkingRegs*8-1:0] rd_data,
   output logic                     vec_ready,
   output logic                     rd_vec_last,
   output logic                     full,
   output logic                     empty
`ifdef VEC_CHUNK_FIFO_ERR_EN
   ,
   output logic                     overflow,
   output logic                     underflow
`endif
);

   localparam int Cpv     = InVecLength / WorkingRegs;
   localparam int Cap     = VecDepth * Cpv;
   localparam int PtrW    = (Cap > 1) ? $clog2(Cap) : 1;
   localparam int IdxW    = (Cpv > 1) ? $clog2(Cpv) : 1;
   localparam int CntW    = $clog2(Cap + 1);
   localparam int VecCntW = $clog2(VecDepth + 1);

   logic [WorkingRegs*8-1:0] mem_q [Cap];

   logic [PtrW-1:0]    wrPtr_q, wrPtr_d;
   logic [PtrW-1:0]    rdPtr_q, rdPtr_d;
   logic [IdxW-1:0]    wrIdx_q, wrIdx_d;
   logic [IdxW-1:0]    rdIdx_q, rdIdx_d;
   logic [CntW-1:0]    count_q, count_d;
   logic [VecCntW-1:0] vecCount_q, vecCount_d;
   logic               vecReady_q;

   logic wrEn;
   logic rdEn;
   logic vecInc;
   logic vecDec;

   assign full        = (count_q == CntW'(Cap));
   assign empty       = (count_q == '0);
   assign vec_ready   = vecReady_q;
   assign rd_vec_last = (rdIdx_q == IdxW'(Cpv - 1));
   assign rd_data     = empty ? '0 : mem_q[rdPtr_q];

   // Next-state for pointers, chunk indices, occupancy and vector count.
   // Pointers and indices wrap explicitly so Cap and Cpv need not be powers
   // of two. A vector completes when the last chunk of a vector is written
   // and is consumed when its last chunk is popped; both at once cancel.
   always_comb begin
      wrEn       = wr_chunk && !full;
      rdEn       = rd_chunk && !empty;
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      wrIdx_d    = wrIdx_q;
      rdIdx_d    = rdIdx_q;
      count_d    = count_q;
      vecCount_d = vecCount_q;
      vecInc     = wrEn && (wrIdx_q == IdxW'(Cpv - 1));
      vecDec     = rdEn && (rdIdx_q == IdxW'(Cpv - 1));

      if (wrEn) begin
         wrPtr_d = (wrPtr_q == PtrW'(Cap - 1)) ? '0 : wrPtr_q + PtrW'(1);
         wrIdx_d = (wrIdx_q == IdxW'(Cpv - 1)) ? '0 : wrIdx_q + IdxW'(1);
      end
      if (rdEn) begin
         rdPtr_d = (rdPtr_q == PtrW'(Cap - 1)) ? '0 : rdPtr_q + PtrW'(1);
         rdIdx_d = (rdIdx_q == IdxW'(Cpv - 1)) ? '0 : rdIdx_q + IdxW'(1);
      end

      case ({wrEn, rdEn})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase

      case ({vecInc, vecDec})
         2'b10:   vecCount_d = vecCount_q + VecCntW'(1);
         2'b01:   vecCount_d = vecCount_q - VecCntW'(1);
         default: vecCount_d = vecCount_q;
      endcase
   end

   // Control state register; reset discards any partial vector.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         wrIdx_q    <= '0;
         rdIdx_q    <= '0;
         count_q    <= '0;
         vecCount_q <= '0;
         vecReady_q <= 1'b0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         wrIdx_q    <= wrIdx_d;
         rdIdx_q    <= rdIdx_d;
         count_q    <= count_d;
         vecCount_q <= vecCount_d;
         vecReady_q <= (vecCount_d != '0);
      end
   end

   // Data storage needs no reset; empty masks stale contents on rd_data.
   always_ff @(posedge clk_in) begin
      if (!rst_in && wrEn) begin
         mem_q[wrPtr_q] <= wr_data;
      end
   end

`ifdef VEC_CHUNK_FIFO_ERR_EN
   logic overflow_q;
   logic underflow_q;

   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_chunk && full) begin
            overflow_q <= 1'b1;
         end
         if (rd_chunk && empty) begin
            underflow_q <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_vec_chunk_fifo.sv
// tb_vec_chunk_fifo
// Directed bench for vec_chunk_fifo with InVecLength=8, WorkingRegs=2,
// VecDepth=2 (4 chunks per vector, 8 chunk capacity). A queue-based model
// tracks stored chunks tagged with "last of vector"; a compare process checks
// every output against it on each falling edge, and literal expectations pin
// the key scenarios.
module tb_vec_chunk_fifo;

   localparam int InVecLength = 8;
   localparam int WorkingRegs = 2;
   localparam int VecDepth    = 2;
   localparam int Cpv         = InVecLength / WorkingRegs;
   localparam int Cap         = VecDepth * Cpv;

   logic        clk;
   logic        rstIn;
   logic        wrChunk;
   logic [15:0] wrData;
   logic        rdChunk;
   logic [15:0] rdData;
   logic        vecReady;
   logic        rdVecLast;
   logic        fullOut;
   logic        emptyOut;
`ifdef VEC_CHUNK_FIFO_ERR_EN
   logic        overflowOut;
   logic        underflowOut;
`endif

   int checks = 0;
   int errors = 0;

   vec_chunk_fifo #(
      .InVecLength(InVecLength),
      .WorkingRegs(WorkingRegs),
      .VecDepth   (VecDepth)
   ) dut (
      .clk_in     (clk),
      .rst_in     (rstIn),
      .wr_chunk   (wrChunk),
      .wr_data    (wrData),
      .rd_chunk   (rdChunk),
      .rd_data    (rdData),
      .vec_ready  (vecReady),
      .rd_vec_last(rdVecLast),
      .full       (fullOut),
      .empty      (emptyOut)
`ifdef VEC_CHUNK_FIFO_ERR_EN
      ,
      .overflow   (overflowOut),
      .underflow  (underflowOut)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: queue of stored chunks, each tagged with whether it
   // closes a vector, plus running write/pop totals.
   typedef struct {
      logic [15:0] data;
      bit          last;
   } entry_t;

   entry_t modelQ[$];
   int     wrTotal    = 0;
   int     popTotal   = 0;
   bit     modelOvf   = 0;
   bit     modelUnf   = 0;
   bit     modelValid = 0;

   always @(posedge clk) begin
      bit mFull;
      bit mEmpty;
      entry_t e;
      if (rstIn) begin
         modelQ.delete();
         wrTotal    = 0;
         popTotal   = 0;
         modelOvf   = 0;
         modelUnf   = 0;
         modelValid = 1;
      end else begin
         mFull  = (modelQ.size() == Cap);
         mEmpty = (modelQ.size() == 0);
         if (wrChunk && mFull) modelOvf = 1;
         if (rdChunk && mEmpty) modelUnf = 1;
         if (rdChunk && !mEmpty) begin
            void'(modelQ.pop_front());
            popTotal++;
         end
         if (wrChunk && !mFull) begin
            e.data = wrData;
            e.last = ((wrTotal % Cpv) == Cpv - 1);
            modelQ.push_back(e);
            wrTotal++;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      logic [15:0] expData;
      bit          expVec;
      if (modelValid) begin
         expData = (modelQ.size() == 0) ? 16'h0 : modelQ[0].data;
         expVec  = 0;
         foreach (modelQ[i]) if (modelQ[i].last) expVec = 1;
         checkOutput("cyc_rd_data", 32'(rdData), 32'(expData));
         checkOutput("cyc_empty", 32'(emptyOut), 32'(modelQ.size() == 0));
         checkOutput("cyc_full", 32'(fullOut), 32'(modelQ.size() == Cap));
         checkOutput("cyc_vec_ready", 32'(vecReady), 32'(expVec));
         checkOutput("cyc_rd_vec_last", 32'(rdVecLast), 32'((popTotal % Cpv) == Cpv - 1));
`ifdef VEC_CHUNK_FIFO_ERR_EN
         checkOutput("cyc_overflow", 32'(overflowOut), 32'(modelOvf));
         checkOutput("cyc_underflow", 32'(underflowOut), 32'(modelUnf));
`endif
      end
   end

   function automatic logic [15:0] packChunk(input int e0, input int e1);
      return {8'(e1), 8'(e0)};
   endfunction

   task automatic applyStimulus(input logic wr, input logic [15:0] d, input logic rd);
      @(negedge clk);
      wrChunk = wr;
      wrData  = d;
      rdChunk = rd;
      @(posedge clk);
      #1;
      wrChunk = 1'b0;
      rdChunk = 1'b0;
      wrData  = '0;
   endtask

   // Reset with a simultaneous write and read to exercise reset priority.
   task automatic doReset();
      @(negedge clk);
      rstIn   = 1'b1;
      wrChunk = 1'b1;
      rdChunk = 1'b1;
      wrData  = 16'hA5A5;
      @(posedge clk);
      #1;
      rstIn   = 1'b0;
      wrChunk = 1'b0;
      rdChunk = 1'b0;
      wrData  = '0;
   endtask

   logic [15:0] popExp [4];

   initial begin
      rstIn   = 1'b1;
      wrChunk = 1'b0;
      rdChunk = 1'b0;
      wrData  = '0;
      doReset();

      $display("[TB] reset state");
      checkOutput("rst_empty", 32'(emptyOut), 32'd1);
      checkOutput("rst_full", 32'(fullOut), 32'd0);
      checkOutput("rst_vec_ready", 32'(vecReady), 32'd0);
      checkOutput("rst_rd_vec_last", 32'(rdVecLast), 32'd0);
      checkOutput("rst_rd_data", 32'(rdData), 32'd0);

      $display("[TB] one vector in");
      applyStimulus(1'b1, packChunk(1, 2), 1'b0);
      checkOutput("w1_vec_ready", 32'(vecReady), 32'd0);
      applyStimulus(1'b1, packChunk(3, 4), 1'b0);
      checkOutput("w2_vec_ready", 32'(vecReady), 32'd0);
      applyStimulus(1'b1, packChunk(5, 6), 1'b0);
      checkOutput("w3_vec_ready", 32'(vecReady), 32'd0);
      applyStimulus(1'b1, packChunk(7, 8), 1'b0);
      checkOutput("w4_vec_ready", 32'(vecReady), 32'd1);
      checkOutput("w4_rd_data", 32'(rdData), 32'h0201);

      $display("[TB] one vector out");
      popExp[0] = 16'h0201;
      popExp[1] = 16'h0403;
      popExp[2] = 16'h0605;
      popExp[3] = 16'h0807;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("pop%0d_rd_data", i), 32'(rdData), 32'(popExp[i]));
         checkOutput($sformatf("pop%0d_rd_vec_last", i), 32'(rdVecLast), 32'(i == 3));
         applyStimulus(1'b0, 16'h0, 1'b1);
      end
      checkOutput("drain_vec_ready", 32'(vecReady), 32'd0);
      checkOutput("drain_empty", 32'(emptyOut), 32'd1);

      $display("[TB] fill to capacity then write while full");
      doReset();
      for (int k = 0; k < 8; k++) applyStimulus(1'b1, packChunk(10 + k, 20 + k), 1'b0);
      checkOutput("fill_full", 32'(fullOut), 32'd1);
      applyStimulus(1'b1, packChunk(99, 99), 1'b1);
      checkOutput("ovf_full", 32'(fullOut), 32'd0);
      checkOutput("ovf_rd_data", 32'(rdData), 32'h150B);
`ifdef VEC_CHUNK_FIFO_ERR_EN
      checkOutput("ovf_flag", 32'(overflowOut), 32'd1);
`endif
      for (int k = 0; k < 6; k++) applyStimulus(1'b0, 16'h0, 1'b1);
      checkOutput("ovf_tail_data", 32'(rdData), 32'h1B11);
      applyStimulus(1'b0, 16'h0, 1'b1);
      checkOutput("ovf_drained_empty", 32'(emptyOut), 32'd1);

      $display("[TB] read on empty with simultaneous write");
      applyStimulus(1'b1, packChunk(9, 9), 1'b1);
      checkOutput("unf_empty", 32'(emptyOut), 32'd0);
      checkOutput("unf_full", 32'(fullOut), 32'd0);
      checkOutput("unf_rd_data", 32'(rdData), 32'h0909);
`ifdef VEC_CHUNK_FIFO_ERR_EN
      checkOutput("unf_flag", 32'(underflowOut), 32'd1);
`endif

      $display("[TB] streaming read/write with pointer wrap");
      doReset();
      for (int n = 0; n < 4; n++) applyStimulus(1'b1, packChunk(n + 1, n + 101), 1'b0);
      for (int n = 4; n < 24; n++) applyStimulus(1'b1, packChunk(n + 1, n + 101), 1'b1);
      checkOutput("stream_vec_ready", 32'(vecReady), 32'd1);
      checkOutput("stream_rd_data", 32'(rdData), 32'h7915);
      checkOutput("stream_empty", 32'(emptyOut), 32'd0);

      $display("[TB] reset mid-vector");
      doReset();
      applyStimulus(1'b0, 16'h0, 1'b1);
      applyStimulus(1'b1, packChunk(1, 1), 1'b0);
      applyStimulus(1'b1, packChunk(2, 2), 1'b0);
      doReset();
      checkOutput("mid_empty", 32'(emptyOut), 32'd1);
      checkOutput("mid_vec_ready", 32'(vecReady), 32'd0);
      checkOutput("mid_rd_data", 32'(rdData), 32'd0);
`ifdef VEC_CHUNK_FIFO_ERR_EN
      checkOutput("mid_overflow", 32'(overflowOut), 32'd0);
      checkOutput("mid_underflow", 32'(underflowOut), 32'd0);
`endif
      for (int n = 0; n < 3; n++) applyStimulus(1'b1, packChunk(n + 40, n + 50), 1'b0);
      checkOutput("mid_partial_vec_ready", 32'(vecReady), 32'd0);
      applyStimulus(1'b1, packChunk(43, 53), 1'b0);
      checkOutput("mid_full_vec_ready", 32'(vecReady), 32'd1);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
